alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Alarm control FSM between the timekeeping core and the display/LED driver.
//  Compares running clock time against the stored alarm time and sequences
//  ring / snooze / stop / ring-timeout.
//  Produces the alarm trigger consumed by the display block.
//  Time words are 20-bit BCD: {h_t[1:0],h_u[3:0],m_t[2:0],m_u[3:0],s_t[2:0],s_u[3:0]}.
// PARAMETERS
//  RING_TIMEOUT_S  60   seconds of ringing before auto-stop (>=1)
//  SNOOZE_S        300  seconds spent in snooze before re-ring (>=1)
//  MAX_SNOOZE      3    snoozes allowed per alarm event (>=1)
// PORTS
//  clk          in   1   system clock (100 MHz)
//  reset        in   1   synchronous, active-high reset
//  tick_1s      in   1   one-cycle pulse per second, clk_time valid in that cycle
//  clk_time     in   20  current clock time (BCD, format above)
//  alarm_time   in   20  stored alarm time; only hh:mm bits [19:7] compared
//  arm          in   1   alarm enable switch (level)
//  snooze_btn   in   1   debounced snooze button (level)
//  stop_btn     in   1   debounced stop button (level)
//  alarm        out  1   1 while RINGING (registered)
//  state        out  2   0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZING
//  snooze_cnt   out  CW  snoozes used in current event, CW=$clog2(MAX_SNOOZE+1)
// BEHAVIOUR
//  Reset: state=DISARMED, alarm=0, snooze_cnt=0, sec counter=0.
//  Reset: button-history regs=1, so a button held through reset gives no edge.
//  Button inputs: rising-edge detected via 1 flop each; edge valid one cycle.
//  match = tick_1s & clk_time[19:7]==alarm_time[19:7] & clk_time[6:0]==0.
//  All transitions registered: event in cycle N -> state/outputs change at N+1.
//  Priority per cycle: arm==0 > stop edge > snooze edge > tick-driven events.
//  Any state, arm==0: -> DISARMED; clear snooze_cnt and sec counter.
//  DISARMED, arm==1: -> ARMED.
//  ARMED, match: -> RINGING; sec counter=0, snooze_cnt=0.
//  ARMED, non-match: hold.
//  RINGING, stop edge: -> ARMED; snooze_cnt=0.
//  RINGING, snooze edge & snooze_cnt<MAX_SNOOZE: -> SNOOZING.
//    On that transition: snooze_cnt+1, sec counter=0.
//  RINGING, snooze edge & snooze_cnt==MAX_SNOOZE: ignored; stays RINGING.
//  RINGING, tick_1s: sec counter+1.
//    On the tick that brings it to RING_TIMEOUT_S: -> ARMED; counter and snooze_cnt=0.
//  SNOOZING, stop edge: -> ARMED; snooze_cnt=0.
//  SNOOZING, snooze edge: ignored.
//  SNOOZING, tick_1s: sec counter+1.
//    On reaching SNOOZE_S: -> RINGING; counter=0, snooze_cnt kept.
//  match while RINGING/SNOOZING: ignored; no restart of the counter.
//  Edge and tick in the same cycle: edge wins; tick is not counted.
//  Sec counter width $clog2(max(RING_TIMEOUT_S,SNOOZE_S)+1); never wraps.
//  Counter is cleared on every state change.
//  alarm == (state==RINGING), driven from a flop, never combinational.
//  Mid-operation reset or arm drop while RINGING: alarm=0 on the next cycle.
// TESTING (sim params RING_TIMEOUT_S=4, SNOOZE_S=3, MAX_SNOOZE=2)
//  1. arm=1, alarm_time=07:30, tick with clk_time=07:30:00
//     -> state=2, alarm=1 one cycle after the tick.
//  2. Ringing, 4 ticks, no buttons
//     -> state=1, alarm=0 after 4th tick; snooze_cnt=0.
//  3. Ringing, snooze edge -> state=3, snooze_cnt=1; 3 ticks -> state=2.
//     Snooze again -> cnt=2; 3 ticks -> ring; 3rd snooze ignored (state stays 2).
//  4. Snoozing, stop edge -> state=1, snooze_cnt=0.
//     Tick at 07:31:00 produces no ring.
//  5. Ringing, arm deasserted
//     -> state=0, alarm=0 next cycle; later match with arm=0 -> stays 0.
//  6. Snooze and stop edges in same cycle while ringing -> stop wins (state=1).
//     Reset with stop_btn held, release and re-press -> exactly one edge.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// Handshake bundle between timekeeping core, alarm sequencer and display driver.
// The master side drives time/buttons and observes the alarm status.
interface alarm_sequencer_if #(
  parameter int MAX_SNOOZE = 3
);
  localparam int CW = $clog2(MAX_SNOOZE + 1);

  logic          tick_1s;
  logic [19:0]   clk_time;
  logic [19:0]   alarm_time;
  logic          arm;
  logic          snooze_btn;
  logic          stop_btn;
  logic          alarm;
  logic [1:0]    state;
  logic [CW-1:0] snooze_cnt;

  modport master (
    output tick_1s, clk_time, alarm_time, arm, snooze_btn, stop_btn,
    input  alarm, state, snooze_cnt
  );

  modport slave (
    input  tick_1s, clk_time, alarm_time, arm, snooze_btn, stop_btn,
    output alarm, state, snooze_cnt
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm FSM: compares running time to alarm hh:mm and sequences
// ring / snooze / stop / ring-timeout. All outputs come straight from flops.
module alarm_sequencer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic               clk,
  input  logic               reset,
  alarm_sequencer_if.slave   bus
);
  localparam int CW   = $clog2(MAX_SNOOZE + 1);
  localparam int SMAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int SCW  = $clog2(SMAX + 1);

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_RINGING  = 2'd2;
  localparam logic [1:0] S_SNOOZING = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SCW-1:0] sec_q, sec_d;
  logic           alarm_q;
  logic           stop_prev_q, snz_prev_q;

  logic stop_edge, snz_edge, match;

  assign stop_edge = bus.stop_btn & ~stop_prev_q;
  assign snz_edge  = bus.snooze_btn & ~snz_prev_q;
  assign match     = bus.tick_1s
                   & (bus.clk_time[19:7] == bus.alarm_time[19:7])
                   & (bus.clk_time[6:0] == 7'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sec_d   = sec_q;
    if (!bus.arm) begin
      state_d = S_DISARMED;
      cnt_d   = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        S_DISARMED: begin
          state_d = S_ARMED;
          sec_d   = '0;
        end
        S_ARMED: begin
          if (match) begin
            state_d = S_RINGING;
            sec_d   = '0;
            cnt_d   = '0;
          end
        end
        S_RINGING: begin
          if (stop_edge) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            sec_d   = '0;
          end else if (snz_edge && (cnt_q < CW'(MAX_SNOOZE))) begin
            state_d = S_SNOOZING;
            cnt_d   = cnt_q + CW'(1);
            sec_d   = '0;
          end else if (bus.tick_1s) begin
            // A snooze press beyond the limit has no effect, so the tick still counts.
            if (sec_q == SCW'(RING_TIMEOUT_S - 1)) begin
              state_d = S_ARMED;
              cnt_d   = '0;
              sec_d   = '0;
            end else begin
              sec_d = sec_q + SCW'(1);
            end
          end
        end
        default: begin
          if (stop_edge) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            sec_d   = '0;
          end else if (bus.tick_1s) begin
            if (sec_q == SCW'(SNOOZE_S - 1)) begin
              state_d = S_RINGING;
              sec_d   = '0;
            end else begin
              sec_d = sec_q + SCW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_DISARMED;
      cnt_q       <= '0;
      sec_q       <= '0;
      alarm_q     <= 1'b0;
      // Held-through-reset buttons must not look like a fresh press.
      stop_prev_q <= 1'b1;
      snz_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_q       <= sec_d;
      alarm_q     <= (state_d == S_RINGING);
      stop_prev_q <= bus.stop_btn;
      snz_prev_q  <= bus.snooze_btn;
    end
  end

  assign bus.alarm      = alarm_q;
  assign bus.state      = state_q;
  assign bus.snooze_cnt = cnt_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer with short timeouts (ring 4 s, snooze 3 s, 2 snoozes).
module tb_alarm_sequencer;
  localparam int RT = 4;
  localparam int ST = 3;
  localparam int MS = 2;

  typedef struct packed {
    logic [1:0] st;
    logic       al;
    logic [1:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  res_t  exp_q[$];
  res_t  obs_q[$];
  string name_q[$];

  alarm_sequencer_if #(.MAX_SNOOZE(MS)) bus ();

  alarm_sequencer #(.RING_TIMEOUT_S(RT), .SNOOZE_S(ST), .MAX_SNOOZE(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    logic [19:0] w;
    w = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    return w;
  endfunction

  // Drive one cycle of stimulus, queue the expected post-edge result, record what the DUT shows.
  task automatic drive(input logic rst, input logic arm, input logic tk, input logic [19:0] ct,
                       input logic snz, input logic stp, input logic [1:0] est,
                       input logic [1:0] ecnt, input string nm);
    res_t e, o;
    @(negedge clk);
    reset          = rst;
    bus.arm        = arm;
    bus.tick_1s    = tk;
    bus.clk_time   = ct;
    bus.snooze_btn = snz;
    bus.stop_btn   = stp;
    e.st = est; e.al = (est == 2'd2); e.cnt = ecnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    o.st = bus.state; o.al = bus.alarm; o.cnt = bus.snooze_cnt;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    res_t e, o;
    string nm;
    drive(1, 0, 0, bcd(0, 0, 0), 0, 1, 2'd0, 2'd0, "reset_a");
    drive(1, 1, 1, bcd(7, 30, 0), 1, 1, 2'd0, 2'd0, "reset_b");
    drive(0, 0, 0, bcd(0, 0, 0), 0, 0, 2'd0, 2'd0, "reset_off");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  task automatic test_ring();
    res_t e, o;
    string nm;
    drive(0, 1, 0, bcd(7, 29, 59), 0, 0, 2'd1, 2'd0, "arm_on");
    drive(0, 1, 1, bcd(7, 30, 1), 0, 0, 2'd1, 2'd0, "nomatch_sec");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 0, 2'd1, 2'd0, "nomatch_notick");
    drive(0, 1, 1, bcd(7, 31, 0), 0, 0, 2'd1, 2'd0, "nomatch_min");
    drive(0, 1, 1, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "match_ring");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    res_t e, o;
    string nm;
    for (int i = 1; i <= RT; i++) begin
      drive(0, 1, 0, bcd(7, 30, i), 0, 0, 2'd2, 2'd0, "ring_idle");
      drive(0, 1, 1, bcd(7, 30, i), 0, 0, (i == RT) ? 2'd1 : 2'd2, 2'd0, "ring_tick");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  task automatic test_snooze();
    res_t e, o;
    string nm;
    drive(0, 1, 1, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "rering");
    for (int n = 1; n <= MS; n++) begin
      drive(0, 1, 0, bcd(7, 30, 1), 1, 0, 2'd3, 2'(n), "snooze_edge");
      for (int i = 1; i <= ST; i++)
        drive(0, 1, 1, bcd(7, 30, i), 1, 0, (i == ST) ? 2'd2 : 2'd3, 2'(n), "snooze_tick");
      drive(0, 1, 0, bcd(7, 31, 0), 0, 0, 2'd2, 2'(n), "snooze_release");
    end
    drive(0, 1, 0, bcd(7, 31, 0), 1, 0, 2'd2, 2'(MS), "snooze_over_limit");
    drive(0, 1, 0, bcd(7, 31, 0), 0, 0, 2'd2, 2'(MS), "snooze_over_rel");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  task automatic test_stop();
    res_t e, o;
    string nm;
    drive(0, 1, 0, bcd(7, 31, 0), 0, 1, 2'd1, 2'd0, "stop_ringing");
    drive(0, 1, 1, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "ring_again");
    drive(0, 1, 0, bcd(7, 30, 0), 1, 0, 2'd3, 2'd1, "snooze_once");
    drive(0, 1, 0, bcd(7, 30, 0), 1, 1, 2'd1, 2'd0, "stop_snoozing");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 0, 2'd1, 2'd0, "stop_release");
    drive(0, 1, 1, bcd(7, 31, 0), 0, 0, 2'd1, 2'd0, "no_ring_0731");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  task automatic test_arm_drop();
    res_t e, o;
    string nm;
    drive(0, 1, 1, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "ring_for_drop");
    drive(0, 0, 0, bcd(7, 30, 0), 0, 0, 2'd0, 2'd0, "arm_drop");
    drive(0, 0, 1, bcd(7, 30, 0), 0, 0, 2'd0, 2'd0, "match_disarmed");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    string nm;
    drive(0, 1, 0, bcd(7, 0, 0), 0, 0, 2'd1, 2'd0, "rearm");
    drive(0, 1, 1, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "ring_b2b");
    drive(0, 1, 0, bcd(7, 30, 0), 1, 1, 2'd1, 2'd0, "stop_beats_snooze");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 0, 2'd1, 2'd0, "b2b_release");
    drive(0, 1, 1, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "ring_pre_reset");
    drive(1, 1, 0, bcd(7, 30, 0), 0, 1, 2'd0, 2'd0, "reset_mid_ring");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 1, 2'd1, 2'd0, "post_reset_arm");
    drive(0, 1, 1, bcd(7, 30, 0), 0, 1, 2'd2, 2'd0, "ring_stop_held");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 1, 2'd2, 2'd0, "held_no_edge");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 0, 2'd2, 2'd0, "stop_released");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 1, 2'd1, 2'd0, "stop_repress");
    drive(0, 1, 0, bcd(7, 30, 0), 0, 1, 2'd1, 2'd0, "stop_still_held");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d al=%0d cnt=%0d, want st=%0d al=%0d cnt=%0d",
                 nm, o.st, o.al, o.cnt, e.st, e.al, e.cnt);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.arm        = 1'b0;
    bus.tick_1s    = 1'b0;
    bus.clk_time   = '0;
    bus.alarm_time = bcd(7, 30, 45);  // seconds field must be ignored
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b1;
    test_reset();
    test_ring();
    test_timeout();
    test_snooze();
    test_stop();
    test_arm_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
